// File: rtl/rl_pkg.sv
// ---------------------------------------------------------------------------
// rl_pkg
// Shared definitions for the range-limited force accumulator.
// Contents:
//   state_t        accumulator control states
//   FP_*           IEEE-754 single-precision field positions and exponent bias
//   ACC_MAX/MIN    symmetric saturation limits of the default 48-bit accumulator
// No ports (package).
// ---------------------------------------------------------------------------
package rl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_COMMIT,
    ST_DONE
  } state_t;

  localparam int FP_SIGN_BIT  = 31;
  localparam int FP_EXP_HI    = 30;
  localparam int FP_EXP_LO    = 23;
  localparam int FP_MANT_HI   = 22;
  localparam int FP_MANT_BITS = 23;
  localparam int FP_EXP_BIAS  = 127;

  localparam int DEF_ACC_WIDTH = 48;
  localparam int DEF_FRAC_BITS = 24;

  // The range is symmetric: the most negative two's-complement code is never produced.
  localparam logic [DEF_ACC_WIDTH-1:0] ACC_MAX = 48'h7FFF_FFFF_FFFF;
  localparam logic [DEF_ACC_WIDTH-1:0] ACC_MIN = 48'h8000_0000_0001;

endpackage

// File: rtl/rl_force_accumulator_if.sv
// ---------------------------------------------------------------------------
// rl_force_accumulator_if
// Force stream from the range-limited pipeline into the accumulator.
// Signals:
//   force_in         IEEE-754 force of one pair
//   force_valid      force_in/force_home_addr valid this cycle
//   force_home_addr  home particle the force belongs to
//   flush            end-of-run pulse
//   in_ready         accumulator accepts forces (driven by the sink)
// Modports: master = pipeline side, slave = accumulator side.
// ---------------------------------------------------------------------------
interface rl_force_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);

  logic [DATA_WIDTH-1:0] force_in;
  logic                  force_valid;
  logic [ADDR_WIDTH-1:0] force_home_addr;
  logic                  flush;
  logic                  in_ready;

  modport master (
    output force_in,
    output force_valid,
    output force_home_addr,
    output flush,
    input  in_ready
  );

  modport slave (
    input  force_in,
    input  force_valid,
    input  force_home_addr,
    input  flush,
    output in_ready
  );

endinterface

// File: rtl/rl_float_to_fixed.sv
// ---------------------------------------------------------------------------
// rl_float_to_fixed
// Combinational IEEE-754 single -> signed fixed point, round toward zero.
// Ports:
//   f      in   DATA_WIDTH  float input
//   value  out  ACC_WIDTH   trunc(f * 2**FRAC_BITS), saturated to +/-(2**(ACC_WIDTH-1)-1)
//   sat    out  1           saturation happened (out of range, Inf or NaN)
// Zero and denormals give 0; NaN saturates positive.
// ---------------------------------------------------------------------------
module rl_float_to_fixed
  import rl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int FRAC_BITS  = 24
) (
  input  logic [DATA_WIDTH-1:0]       f,
  output logic signed [ACC_WIDTH-1:0] value,
  output logic                        sat
);

  localparam int WIDE_W = ACC_WIDTH + FP_MANT_BITS + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX_V = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [WIDE_W-1:0] MAX_WIDE = {{(FP_MANT_BITS+2){1'b0}}, {(ACC_WIDTH-1){1'b1}}};

  logic                        sign;
  logic [7:0]                  exp_f;
  logic [FP_MANT_BITS:0]       mant;
  logic                        is_nan;
  logic signed [11:0]          shift;
  logic [11:0]                 rshift;
  logic [WIDE_W-1:0]           wide;
  logic signed [ACC_WIDTH-1:0] mag;

  // The significand 1.m is an integer scaled by 2**-23, so the fixed value is
  // that integer shifted by (exp - bias + FRAC_BITS - 23).  Left shifts are done
  // in a wide word so that anything above the accumulator range is detectable.
  always_comb begin
    sign   = f[FP_SIGN_BIT];
    exp_f  = f[FP_EXP_HI:FP_EXP_LO];
    mant   = {1'b1, f[FP_MANT_HI:0]};
    is_nan = (exp_f == 8'hFF) && (f[FP_MANT_HI:0] != '0);
    shift  = 12'(int'(exp_f) - FP_EXP_BIAS + FRAC_BITS - FP_MANT_BITS);
    rshift = 12'(-shift);
    wide   = '0;
    sat    = 1'b0;
    value  = '0;

    if (exp_f == 8'h00) begin
      wide = '0;
    end else if (exp_f == 8'hFF) begin
      sat = 1'b1;
    end else if (shift < 12'sd0) begin
      wide = WIDE_W'(mant) >> rshift;
    end else if (shift >= 12'(ACC_WIDTH)) begin
      sat = 1'b1;
    end else begin
      wide = WIDE_W'(mant) << shift;
    end

    if (wide > MAX_WIDE) begin
      sat = 1'b1;
    end

    mag = wide[ACC_WIDTH-1:0];
    if (sat) begin
      value = (sign && !is_nan) ? -ACC_MAX_V : ACC_MAX_V;
    end else begin
      value = sign ? -mag : mag;
    end
  end

endmodule

// File: rtl/rl_force_accumulator.sv
// ---------------------------------------------------------------------------
// rl_force_accumulator
// Sink of the range-limited force pipeline.  Converts each float force to
// fixed point, sums all forces of one home particle and writes the finished
// sum into a force cache (one word per home address) that the host reads back.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        pulse in IDLE: clear cache, then accept forces
//   fin          force stream (force_in/force_valid/force_home_addr/flush, in_ready out)
//   busy         high in CLEAR, ACCUM, DRAIN, COMMIT
//   done         one-cycle pulse after the run is committed
//   rd_addr      host read address (any state)
//   rd_data      cache[rd_addr], registered, one cycle latency
//   ovf_err      sticky: saturation (including Inf/NaN input)
//   order_err    sticky: home address revisited non-contiguously
//   drop_err     sticky: force_valid while in_ready low
// Pipeline: S1 registers the converted force, S2 accumulates / evicts.
// ---------------------------------------------------------------------------
module rl_force_accumulator
  import rl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  rl_force_accumulator_if.slave fin,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ACC_WIDTH-1:0]  rd_data,
  output logic                  ovf_err,
  output logic                  order_err,
  output logic                  drop_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX_V = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN_V = -ACC_MAX_V;
  localparam logic signed [ACC_WIDTH:0]   SUM_MAX   = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0]   SUM_MIN   = -SUM_MAX;

  state_t state, state_nxt;
  logic   in_ready_int;
  logic   accept;

  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  drain_cnt;

  logic signed [ACC_WIDTH-1:0] cvt_value;
  logic                        cvt_sat;

  logic                        s1_valid;
  logic signed [ACC_WIDTH-1:0] s1_value;
  logic [ADDR_WIDTH-1:0]       s1_addr;

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        acc_active;
  logic [ADDR_WIDTH-1:0]       cur_home;
  logic [DEPTH-1:0]            committed;

  logic signed [ACC_WIDTH:0]   sum_wide;
  logic signed [ACC_WIDTH-1:0] sum_sat;
  logic                        sum_clamped;
  logic                        same_home;
  logic                        evict;
  logic                        commit_wr;

  logic                  cache_we;
  logic [ADDR_WIDTH-1:0] cache_waddr;
  logic [ACC_WIDTH-1:0]  cache_wdata;
  logic [ACC_WIDTH-1:0]  cache [DEPTH];

  assign fin.in_ready = in_ready_int;
  assign accept       = in_ready_int && fin.force_valid;

  rl_float_to_fixed #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_cvt (
    .f     (fin.force_in),
    .value (cvt_value),
    .sat   (cvt_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    in_ready_int = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (&clr_cnt) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        busy         = 1'b1;
        in_ready_int = 1'b1;
        if (fin.flush) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Two cycles let a force accepted together with flush pass S1 and S2.
        busy = 1'b1;
        if (drain_cnt) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      clr_cnt   <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // S1: converted force and its home address.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept;
      s1_value <= cvt_value;
      s1_addr  <= fin.force_home_addr;
    end
  end

  // Both operands lie within +/-ACC_MAX, so one extra bit holds the exact sum.
  always_comb begin
    sum_wide    = {acc[ACC_WIDTH-1], acc} + {s1_value[ACC_WIDTH-1], s1_value};
    sum_sat     = sum_wide[ACC_WIDTH-1:0];
    sum_clamped = 1'b0;
    if (sum_wide > SUM_MAX) begin
      sum_sat     = ACC_MAX_V;
      sum_clamped = 1'b1;
    end else if (sum_wide < SUM_MIN) begin
      sum_sat     = ACC_MIN_V;
      sum_clamped = 1'b1;
    end
  end

  assign same_home = acc_active && (s1_addr == cur_home);
  assign evict     = s1_valid && acc_active && (s1_addr != cur_home);
  assign commit_wr = (state == ST_COMMIT) && acc_active;

  // S2: open-sum register for the current home particle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      acc_active <= 1'b0;
      cur_home   <= '0;
    end else if (state == ST_CLEAR) begin
      acc        <= '0;
      acc_active <= 1'b0;
    end else if (state == ST_COMMIT) begin
      acc_active <= 1'b0;
    end else if (s1_valid) begin
      if (same_home) begin
        acc <= sum_sat;
      end else begin
        acc        <= s1_value;
        cur_home   <= s1_addr;
        acc_active <= 1'b1;
      end
    end
  end

  // Eviction and commit both write the open sum; they can never coincide
  // because S1 is empty by the time COMMIT is reached.
  always_comb begin
    cache_we    = 1'b0;
    cache_waddr = cur_home;
    cache_wdata = acc;
    if (state == ST_CLEAR) begin
      cache_we    = 1'b1;
      cache_waddr = clr_cnt;
      cache_wdata = '0;
    end else if (evict || commit_wr) begin
      cache_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      committed <= '0;
    end else if (state == ST_CLEAR) begin
      committed <= '0;
    end else if (cache_we) begin
      committed[cur_home] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we && !rst) begin
      cache[cache_waddr] <= cache_wdata;
    end
  end

  // Separate read process: a same-cycle write to rd_addr returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= cache[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err   <= 1'b0;
      order_err <= 1'b0;
      drop_err  <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      ovf_err   <= 1'b0;
      order_err <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      if ((accept && cvt_sat) || (s1_valid && same_home && sum_clamped)) begin
        ovf_err <= 1'b1;
      end
      if (evict && committed[s1_addr]) begin
        order_err <= 1'b1;
      end
      if (fin.force_valid && !in_ready_int) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rl_force_accumulator.sv
// ---------------------------------------------------------------------------
// tb_rl_force_accumulator
// Directed bench for rl_force_accumulator.  A list-level model computes the
// expected cache contents and error flags of each run; a compare process
// checks rd_data and the error flags against it while the host sweeps reads,
// and literal values pin both the model and the DUT.
// ---------------------------------------------------------------------------
module tb_rl_force_accumulator;

  localparam longint MAXV = 64'sh0000_7FFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic [47:0] rd_data;
  logic        busy, done, ovf_err, order_err, drop_err;

  rl_force_accumulator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) fif ();

  rl_force_accumulator #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (9),
    .ACC_WIDTH  (48),
    .FRAC_BITS  (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fin       (fif),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ovf_err   (ovf_err),
    .order_err (order_err),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] f;
  } force_t;

  force_t      stim_q[$];
  logic [47:0] exp_cache [512];
  bit          exp_ovf, exp_order, exp_drop;
  bit          model_sync = 1'b0;
  bit          sync_seen = 1'b0;
  logic [8:0]  rd_seen = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Real-valued interpretation of the float, scaled by 2**24 and truncated.
  function automatic longint toFix(input logic [31:0] f, output bit sat);
    real r;
    int  e;
    int  k;
    sat = 1'b0;
    e = int'(f[30:23]);
    if (e == 255) begin
      sat = 1'b1;
      if (f[22:0] != 23'd0) return MAXV;
      return f[31] ? -MAXV : MAXV;
    end
    if (e == 0) return 0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    k = e - 127 + 24;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    if (r >= 140737488355328.0) begin
      sat = 1'b1;
      return f[31] ? -MAXV : MAXV;
    end
    return f[31] ? -longint'($floor(r)) : longint'($floor(r));
  endfunction

  // Expected cache after a run of stim_q: contiguous forces of one home form
  // a saturating sum; a home that reappears later overwrites its earlier sum.
  task automatic modelRun(input bit commitEnd);
    bit     seen [512];
    bit     active = 1'b0;
    int     home = 0;
    longint acc = 0;
    longint x;
    bit     s;
    for (int i = 0; i < 512; i++) begin
      exp_cache[i] = '0;
      seen[i] = 1'b0;
    end
    exp_ovf = 1'b0; exp_order = 1'b0; exp_drop = 1'b0;
    foreach (stim_q[n]) begin
      x = toFix(stim_q[n].f, s);
      if (s) exp_ovf = 1'b1;
      if (active && int'(stim_q[n].addr) == home) begin
        acc = acc + x;
        if (acc > MAXV)  begin acc = MAXV;  exp_ovf = 1'b1; end
        if (acc < -MAXV) begin acc = -MAXV; exp_ovf = 1'b1; end
      end else begin
        if (active) begin
          exp_cache[home] = acc[47:0];
          seen[home] = 1'b1;
          if (seen[stim_q[n].addr]) exp_order = 1'b1;
        end
        acc = x;
        home = int'(stim_q[n].addr);
        active = 1'b1;
      end
    end
    if (commitEnd && active) exp_cache[home] = acc[47:0];
  endtask

  always @(posedge clk) begin
    rd_seen   <= rd_addr;
    sync_seen <= model_sync;
  end

  always @(negedge clk) begin
    if (sync_seen && model_sync && !rst) begin
      checkOutput("cache_rd", {16'h0, rd_data}, {16'h0, exp_cache[rd_seen]});
      checkOutput("ovf_err", ovf_err, exp_ovf);
      checkOutput("order_err", order_err, exp_order);
      checkOutput("drop_err", drop_err, exp_drop);
    end
  end

  task automatic addForce(input logic [8:0] a, input logic [31:0] f);
    force_t t;
    t.addr = a;
    t.f = f;
    stim_q.push_back(t);
  endtask

  task automatic beginRun();
    int guard = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (fif.in_ready !== 1'b1 && guard < 700) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("run_ready", fif.in_ready, 1);
  endtask

  task automatic applyStimulus(input bit flushWithLast, input bit endRun);
    int doneCount = 0;
    foreach (stim_q[n]) begin
      fif.force_valid     = 1'b1;
      fif.force_home_addr = stim_q[n].addr;
      fif.force_in        = stim_q[n].f;
      fif.flush           = flushWithLast && (n == stim_q.size() - 1);
      @(posedge clk); #1;
    end
    fif.force_valid = 1'b0;
    fif.flush       = 1'b0;
    if (!endRun) return;
    if (!flushWithLast || stim_q.size() == 0) begin
      fif.flush = 1'b1;
      @(posedge clk); #1;
      fif.flush = 1'b0;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    @(posedge clk); #1;
    checkOutput("done_pulses", doneCount, 1);
    checkOutput("busy_after_run", busy, 0);
    modelRun(1'b1);
  endtask

  task automatic readSweep();
    int addrs [10] = '{0, 1, 3, 4, 5, 7, 9, 10, 100, 511};
    model_sync = 1'b1;
    foreach (addrs[i]) begin
      rd_addr = 9'(addrs[i]);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    model_sync = 1'b0;
  endtask

  task automatic readAddr(input logic [8:0] a, output logic [47:0] v);
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    v = rd_data;
    @(posedge clk); #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_in_ready"}, fif.in_ready, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rd_data"}, {16'h0, rd_data}, 0);
    checkOutput({tag, "_errs"}, {ovf_err, order_err, drop_err}, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] v;
    int badClear;

    fif.force_valid = 1'b0;
    fif.force_in = '0;
    fif.force_home_addr = '0;
    fif.flush = 1'b0;

    // Test 1: reset state, clear window, zeroed cache
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    badClear = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && fif.in_ready === 1'b0)) badClear++;
      @(posedge clk);
    end
    #1;
    checkOutput("clear_window", badClear, 0);
    @(negedge clk);
    checkOutput("ready_after_clear", fif.in_ready, 1);
    @(posedge clk); #1;
    stim_q.delete();
    applyStimulus(1'b0, 1'b1);
    readSweep();
    readAddr(9'd300, v);
    checkOutput("cleared_300", {16'h0, v}, 0);

    // Test 2: two homes, mixed signs
    stim_q.delete();
    addForce(9'd0, 32'h3F800000);
    addForce(9'd0, 32'h40000000);
    addForce(9'd0, 32'hBF000000);
    addForce(9'd1, 32'h40800000);
    beginRun();
    applyStimulus(1'b0, 1'b1);
    checkOutput("model_home0", {16'h0, exp_cache[0]}, 64'h0000_0000_0280_0000);
    checkOutput("model_home1", {16'h0, exp_cache[1]}, 64'h0000_0000_0400_0000);
    readSweep();
    readAddr(9'd0, v);
    checkOutput("home0_sum", {16'h0, v}, 64'h0000_0000_0280_0000);
    readAddr(9'd1, v);
    checkOutput("home1_sum", {16'h0, v}, 64'h0000_0000_0400_0000);

    // Test 3: positive saturation, then -Inf on a fresh run
    stim_q.delete();
    addForce(9'd5, 32'h4B000000);
    beginRun();
    applyStimulus(1'b0, 1'b1);
    checkOutput("model_sat_pos", {16'h0, exp_cache[5]}, 64'h0000_7FFF_FFFF_FFFF);
    readSweep();
    readAddr(9'd5, v);
    checkOutput("sat_pos", {16'h0, v}, 64'h0000_7FFF_FFFF_FFFF);
    checkOutput("ovf_sticky", ovf_err, 1);
    stim_q.delete();
    addForce(9'd5, 32'hFF800000);
    beginRun();
    applyStimulus(1'b0, 1'b1);
    readSweep();
    readAddr(9'd5, v);
    checkOutput("sat_neg_inf", {16'h0, v}, 64'h0000_8000_0000_0001);

    // Test 4: force accepted in the same cycle as flush
    stim_q.delete();
    addForce(9'd7, 32'h3F800000);
    beginRun();
    applyStimulus(1'b1, 1'b1);
    readSweep();
    readAddr(9'd7, v);
    checkOutput("flush_same_cycle", {16'h0, v}, 64'h0000_0000_0100_0000);
    checkOutput("no_drop_on_flush", drop_err, 0);

    // Test 5: non-contiguous revisit of home 3
    stim_q.delete();
    addForce(9'd3, 32'h3F800000);
    addForce(9'd4, 32'h3F800000);
    addForce(9'd3, 32'h40000000);
    beginRun();
    applyStimulus(1'b0, 1'b1);
    checkOutput("model_order", exp_order, 1);
    readSweep();
    readAddr(9'd3, v);
    checkOutput("revisit_home3", {16'h0, v}, 64'h0000_0000_0200_0000);
    readAddr(9'd4, v);
    checkOutput("revisit_home4", {16'h0, v}, 64'h0000_0000_0100_0000);
    checkOutput("order_sticky", order_err, 1);

    // Test 6: drop in IDLE, then reset mid-ACCUM with an open sum
    fif.force_valid = 1'b1;
    fif.force_home_addr = 9'd0;
    fif.force_in = 32'h3F800000;
    @(posedge clk); #1;
    fif.force_valid = 1'b0;
    checkOutput("drop_in_idle", drop_err, 1);
    exp_drop = 1'b1;
    readSweep();
    stim_q.delete();
    addForce(9'd9, 32'h3F800000);
    addForce(9'd10, 32'h40000000);
    beginRun();
    applyStimulus(1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    modelRun(1'b0);
    readSweep();
    readAddr(9'd9, v);
    checkOutput("evicted_before_reset", {16'h0, v}, 64'h0000_0000_0100_0000);
    readAddr(9'd10, v);
    checkOutput("open_sum_discarded", {16'h0, v}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
